// File: rtl/rca_accumulator_pkg.sv
// Shared definitions for the rca_accumulator burst adder.
// Adder width and FSM state encodings.
package rca_accumulator_pkg;

   localparam int RCA_WIDTH = 6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/rca_accumulator_rca.sv
// RippleCarryAdder: plain ripple-carry sum, no carry-out port.
// Carry chain stops at bit W-1, so the wrap is visible only as SUM < A.
module RippleCarryAdder
   import rca_accumulator_pkg::*;
#(
   parameter int W = RCA_WIDTH
) (
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic [W-1:0] SUM
);

   logic [W-1:0] c;

   assign c[0] = 1'b0;

   for (genvar i = 0; i < W; i++) begin : g_bit
      assign SUM[i] = A[i] ^ B[i] ^ c[i];
      if (i < W - 1) begin : g_cy
         assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
      end
   end

endmodule

// File: rtl/rca_accumulator.sv
// Burst accumulator: sums NUM_OPS operands through RippleCarryAdder
// and returns the sum plus a sticky wrap flag on a valid/ready port.
module rca_accumulator
   import rca_accumulator_pkg::*;
#(
   parameter  int WIDTH   = RCA_WIDTH,
   parameter  int NUM_OPS = 4,
   localparam int CNT_W   = $clog2(NUM_OPS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_ovf,
   input  logic             out_ready,
   output logic             busy
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_OPS - 1);

   state_t           state;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] sum_w;
   logic [CNT_W-1:0] cnt;
   logic             ovf_sticky;

   RippleCarryAdder #(
      .W(WIDTH)
   ) u_rca (
      .A  (acc),
      .B  (in_data),
      .SUM(sum_w)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         acc        <= '0;
         cnt        <= '0;
         ovf_sticky <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state      <= ST_ACCUM;
                  acc        <= '0;
                  cnt        <= '0;
                  ovf_sticky <= 1'b0;
               end
            end
            ST_ACCUM: begin
               if (in_valid) begin
                  acc        <= sum_w;
                  ovf_sticky <= ovf_sticky | (sum_w < acc);
                  cnt        <= cnt + CNT_W'(1);
                  if (cnt == LAST) state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Handshake flags decode state only, never the peer's valid/ready.
   assign in_ready  = (state == ST_ACCUM);
   assign out_valid = (state == ST_DONE);
   assign busy      = in_ready | out_valid;
   assign out_sum   = out_valid ? acc : '0;
   assign out_ovf   = out_valid & ovf_sticky;

endmodule

// File: tb/tb_rca_accumulator.sv
// Directed bench for rca_accumulator (NUM_OPS=4 and NUM_OPS=1 builds).
module tb_rca_accumulator;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, in_valid, out_ready;
   logic [5:0] in_data;
   logic       in_ready, out_valid, out_ovf, busy;
   logic [5:0] out_sum;

   logic       start1, in_valid1, out_ready1;
   logic [5:0] in_data1;
   logic       in_ready1, out_valid1, out_ovf1, busy1;
   logic [5:0] out_sum1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rca_accumulator #(.NUM_OPS(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_sum(out_sum), .out_ovf(out_ovf),
      .out_ready(out_ready), .busy(busy)
   );

   rca_accumulator #(.NUM_OPS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1),
      .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
      .out_valid(out_valid1), .out_sum(out_sum1), .out_ovf(out_ovf1),
      .out_ready(out_ready1), .busy(busy1)
   );

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic send(input logic [5:0] d);
      in_valid = 1'b1;
      in_data  = d;
      for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
      if (!in_ready) begin
         checks++; failures++;
         $display("FAIL send_timeout in_ready=%b want 1", in_ready);
      end
      @(negedge clk);
   endtask

   task automatic pulse_start;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain;
      for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      pulse_start();
      send(6'd10);
      send(6'd7);
      in_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset busy=%b in_ready=%b want 1 1", busy, in_ready);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, out_sum, out_ovf, busy, in_ready} !== 10'd0) begin
         failures++;
         $display("FAIL async_reset v=%b s=%0d o=%b b=%b r=%b want all 0",
                  out_valid, out_sum, out_ovf, busy, in_ready);
      end
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b1;
      in_data  = 6'd9;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_accept r=%b b=%b v=%b want 0 0 0",
                     in_ready, busy, out_valid);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_basic;
      pulse_start();
      send(6'd1);
      send(6'd2);
      send(6'd3);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL early_valid out_valid=%b want 0", out_valid);
      end
      send(6'd4);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 6'd10 || out_ovf !== 1'b0
          || in_ready !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL basic_sum v=%b s=%0d o=%b r=%b b=%b want 1 10 0 0 1",
                  out_valid, out_sum, out_ovf, in_ready, busy);
      end
      drain();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== 6'd0) begin
         failures++;
         $display("FAIL basic_idle v=%b b=%b s=%0d want 0 0 0",
                  out_valid, busy, out_sum);
      end
   endtask

   task automatic test_overflow;
      pulse_start();
      send(6'd63); send(6'd1); send(6'd0); send(6'd0);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 6'd0 || out_ovf !== 1'b1) begin
         failures++;
         $display("FAIL ovf_wrap v=%b s=%0d o=%b want 1 0 1",
                  out_valid, out_sum, out_ovf);
      end
      drain();
      pulse_start();
      send(6'd2); send(6'd2); send(6'd2); send(6'd2);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 6'd8 || out_ovf !== 1'b0) begin
         failures++;
         $display("FAIL ovf_cleared v=%b s=%0d o=%b want 1 8 0",
                  out_valid, out_sum, out_ovf);
      end
      drain();
      pulse_start();
      send(6'd0); send(6'd0); send(6'd0); send(6'd0);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 6'd0 || out_ovf !== 1'b0) begin
         failures++;
         $display("FAIL all_zero v=%b s=%0d o=%b want 1 0 0",
                  out_valid, out_sum, out_ovf);
      end
      drain();
   endtask

   task automatic test_gaps_backpressure;
      pulse_start();
      for (int k = 0; k < 4; k++) begin
         send(6'd5);
         in_valid = 1'b0;
         if (k < 3) begin
            for (int g = 0; g < 2; g++) begin
               @(negedge clk);
               checks++;
               if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                  failures++;
                  $display("FAIL gap_stall r=%b v=%b want 1 0",
                           in_ready, out_valid);
               end
            end
         end
      end
      for (int h = 0; h < 4; h++) begin
         checks++;
         if (out_valid !== 1'b1 || out_sum !== 6'd20 || out_ovf !== 1'b0) begin
            failures++;
            $display("FAIL hold_stable cyc=%0d v=%b s=%0d o=%b want 1 20 0",
                     h, out_valid, out_sum, out_ovf);
         end
         if (h < 3) @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL release v=%b b=%b want 0 0", out_valid, busy);
      end
   endtask

   task automatic test_ignored_controls;
      in_valid = 1'b1;
      in_data  = 6'd9;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL idle_ready in_ready=%b want 0", in_ready);
      end
      in_valid = 1'b0;
      pulse_start();
      send(6'd10);
      send(6'd10);
      start = 1'b1;
      send(6'd10);
      start = 1'b0;
      send(6'd10);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 6'd40 || out_ovf !== 1'b0) begin
         failures++;
         $display("FAIL no_restart v=%b s=%0d o=%b want 1 40 0",
                  out_valid, out_sum, out_ovf);
      end
      out_ready = 1'b1;
      start     = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      start     = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL start_at_handshake b=%b r=%b want 0 0", busy, in_ready);
      end
   endtask

   task automatic test_single_op;
      start1 = 1'b1;
      @(negedge clk);
      start1    = 1'b0;
      in_valid1 = 1'b1;
      in_data1  = 6'd42;
      checks++;
      if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
         failures++;
         $display("FAIL one_ready r=%b v=%b want 1 0", in_ready1, out_valid1);
      end
      @(negedge clk);
      in_valid1 = 1'b0;
      checks++;
      if (out_valid1 !== 1'b1 || out_sum1 !== 6'd42 || out_ovf1 !== 1'b0
          || busy1 !== 1'b1) begin
         failures++;
         $display("FAIL one_result v=%b s=%0d o=%b b=%b want 1 42 0 1",
                  out_valid1, out_sum1, out_ovf1, busy1);
      end
      out_ready1 = 1'b1;
      @(negedge clk);
      out_ready1 = 1'b0;
      checks++;
      if (out_valid1 !== 1'b0 || busy1 !== 1'b0) begin
         failures++;
         $display("FAIL one_idle v=%b b=%b want 0 0", out_valid1, busy1);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      start1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({out_valid, out_sum, out_ovf, busy, in_ready} !== 10'd0) begin
         failures++;
         $display("FAIL reset_state v=%b s=%0d o=%b b=%b r=%b want all 0",
                  out_valid, out_sum, out_ovf, busy, in_ready);
      end
      rst_n = 1'b1;
      test_reset();
      test_basic();
      test_overflow();
      test_gaps_backpressure();
      test_ignored_controls();
      test_single_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
